// File: rtl/delay_line_var_if.sv
// Bus between the PRBS aligner and its driver: shift controls, selector, data in and out.
// out_valid is a level, not a handshake: high means signal_out carries a sample shifted in under active_sel.
interface delay_line_var_if #(
    parameter int DATA_W = 1,
    parameter int SEL_W  = 2
);
    logic              enable;
    logic              load;
    logic [SEL_W-1:0]  delay_select;
    logic [DATA_W-1:0] signal_in;
    logic [DATA_W-1:0] signal_out;
    logic              out_valid;
    logic [SEL_W-1:0]  active_sel;

    modport master (
        output enable, load, delay_select, signal_in,
        input  signal_out, out_valid, active_sel
    );

    modport slave (
        input  enable, load, delay_select, signal_in,
        output signal_out, out_valid, active_sel
    );
endinterface

// File: rtl/delay_line_var.sv
// Variable-tap delay line aligning the reference PRBS to the looped-back stream.
// A settle counter holds out_valid low until the line is filled under the current tap.
module delay_line_var #(
    parameter int DATA_W    = 1,
    parameter int MIN_DELAY = 3,
    parameter int SEL_W     = 2
) (
    input logic             clk,
    input logic             reset,
    delay_line_var_if.slave bus
);
    localparam int MAX_DELAY = MIN_DELAY + (1 << SEL_W) - 1;
    localparam int CNT_W     = $clog2(MAX_DELAY + 1);
    localparam int TAP_W     = (MAX_DELAY > 1) ? $clog2(MAX_DELAY) : 1;

    logic [DATA_W-1:0] stage [MAX_DELAY];
    logic [SEL_W-1:0]  sel_q;
    logic [CNT_W-1:0]  cnt;
    logic [TAP_W-1:0]  tap;
    logic [CNT_W-1:0]  need;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < MAX_DELAY; k++) begin
                stage[k] <= '0;
            end
            sel_q <= '0;
            cnt   <= '0;
        end else begin
            if (bus.enable) begin
                stage[0] <= bus.signal_in;
                for (int k = 1; k < MAX_DELAY; k++) begin
                    stage[k] <= stage[k-1];
                end
            end
            if (bus.load) begin
                sel_q <= bus.delay_select;
            end
            // A load restarts settling even when it coincides with a shift.
            if (bus.load) begin
                cnt <= '0;
            end else if (bus.enable && (cnt != CNT_W'(MAX_DELAY))) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    always_comb begin
        tap  = TAP_W'(MIN_DELAY - 1) + TAP_W'(sel_q);
        need = CNT_W'(MIN_DELAY) + CNT_W'(sel_q);
    end

    assign bus.signal_out = stage[tap];
    assign bus.out_valid  = (cnt >= need);
    assign bus.active_sel = sel_q;
endmodule

// File: tb/tb_delay_line_var.sv
// Randomised scoreboard bench for delay_line_var, plus a wide-data / short-delay configuration sweep.
module tb_delay_line_var;
    localparam int DATA_W    = 1;
    localparam int MIN_DELAY = 3;
    localparam int SEL_W     = 2;
    localparam int MAX_DELAY = MIN_DELAY + (1 << SEL_W) - 1;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic reset2 = 1'b1;

    always #5 clk = ~clk;

    delay_line_var_if #(.DATA_W(DATA_W), .SEL_W(SEL_W)) bus ();
    delay_line_var_if #(.DATA_W(8), .SEL_W(3)) bus2 ();

    delay_line_var #(.DATA_W(DATA_W), .MIN_DELAY(MIN_DELAY), .SEL_W(SEL_W)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    delay_line_var #(.DATA_W(8), .MIN_DELAY(1), .SEL_W(3)) dut2 (
        .clk(clk), .reset(reset2), .bus(bus2)
    );

    int checks = 0;
    int errors = 0;
    logic mon_on = 1'b0;

    // Reference model: history of enabled samples (newest first), selector, edges since load/reset.
    logic [DATA_W-1:0] hist[$];
    logic [DATA_W-1:0] exp_q[$];
    int               m_sel = 0;
    int               m_edges = 0;
    logic             m_valid = 1'b0;

    function automatic logic [DATA_W-1:0] model_out();
        int d;
        d = MIN_DELAY + m_sel;
        if (hist.size() >= d) return hist[d-1];
        return '0;
    endfunction

    task automatic step(input logic en, input logic ld, input int ds, input logic [DATA_W-1:0] din);
        @(negedge clk);
        reset = 1'b0;
        bus.enable = en;
        bus.load = ld;
        bus.delay_select = SEL_W'(ds);
        bus.signal_in = din;
        if (en) begin
            hist.push_front(din);
            if (hist.size() > MAX_DELAY) void'(hist.pop_back());
        end
        if (ld) begin
            m_sel = ds;
            m_edges = 0;
        end else if (en) begin
            m_edges++;
        end
        m_valid = (m_edges >= MIN_DELAY + m_sel);
        if (m_valid) exp_q.push_back(model_out());
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        bus.enable = 1'b1;
        bus.load = 1'b1;
        bus.delay_select = SEL_W'($urandom_range(0, (1 << SEL_W) - 1));
        bus.signal_in = DATA_W'($urandom);
        hist.delete();
        exp_q.delete();
        m_sel = 0;
        m_edges = 0;
        m_valid = 1'b0;
        mon_on = 1'b1;
        @(posedge clk);
        #2;
        checks++;
        if (bus.signal_out !== '0) begin
            errors++;
            $display("FAIL reset_signal_out: got %0h expected 0", bus.signal_out);
        end
    endtask

    // Monitor: per-cycle status checks and queue-ordered data checks whenever out_valid is high.
    always @(posedge clk) begin
        if (mon_on) begin
            #1;
            checks++;
            if (bus.out_valid !== m_valid) begin
                errors++;
                $display("FAIL out_valid @%0t: got %b expected %b", $time, bus.out_valid, m_valid);
            end
            checks++;
            if (int'(bus.active_sel) != m_sel) begin
                errors++;
                $display("FAIL active_sel @%0t: got %0d expected %0d", $time, bus.active_sel, m_sel);
            end
            if (bus.out_valid === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL data_unexpected @%0t: got %0h with nothing expected", $time, bus.signal_out);
                end else begin
                    logic [DATA_W-1:0] e;
                    e = exp_q.pop_front();
                    if (bus.signal_out !== e) begin
                        errors++;
                        $display("FAIL data @%0t: got %0h expected %0h", $time, bus.signal_out, e);
                    end
                end
            end
        end
    end

    initial begin
        logic [7:0] pat;
        bus.enable = 1'b0;
        bus.load = 1'b0;
        bus.delay_select = '0;
        bus.signal_in = '0;
        bus2.enable = 1'b0;
        bus2.load = 1'b0;
        bus2.delay_select = '0;
        bus2.signal_in = '0;

        // Impulse at selector 0.
        do_reset();
        step(1'b1, 1'b0, 0, 1'b1);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 0, 1'b0);

        // Selector 3 with the 0x2D pattern, MSB first.
        pat = 8'h2D;
        step(1'b0, 1'b1, 3, 1'b0);
        for (int i = 7; i >= 0; i--) step(1'b1, 1'b0, 0, pat[i]);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 0, 1'b0);

        // delay_select wiggles without load must be ignored.
        do_reset();
        for (int i = 0; i < 16; i++) step(1'b1, 1'b0, (i % 2) * 2, DATA_W'($urandom));

        // Freeze mid-stream at selector 1.
        step(1'b0, 1'b1, 1, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 0, DATA_W'($urandom));
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 0, DATA_W'($urandom));
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 0, DATA_W'($urandom));

        // Load and enable together.
        step(1'b1, 1'b1, 2, 1'b1);
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 0, DATA_W'($urandom));

        // Reset while valid at selector 3, then recover.
        step(1'b0, 1'b1, 3, 1'b0);
        for (int i = 0; i < 9; i++) step(1'b1, 1'b0, 0, DATA_W'($urandom));
        do_reset();
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 0, DATA_W'($urandom));

        // Random mix.
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end else begin
                step(($urandom_range(0, 3) != 0), ($urandom_range(0, 19) == 0),
                     $urandom_range(0, (1 << SEL_W) - 1), DATA_W'($urandom));
            end
        end
        @(negedge clk);
        mon_on = 1'b0;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL leftover_expected: got %0d entries expected 0", exp_q.size());
        end

        // Second configuration: byte 0xA5 must emerge after sel+1 enabled edges.
        for (int s = 0; s < 8; s++) begin
            int found;
            logic v_at;
            found = 0;
            v_at = 1'b0;
            @(negedge clk);
            reset2 = 1'b1;
            @(negedge clk);
            reset2 = 1'b0;
            bus2.load = 1'b1;
            bus2.delay_select = 3'(s);
            bus2.enable = 1'b0;
            @(negedge clk);
            bus2.load = 1'b0;
            bus2.enable = 1'b1;
            bus2.signal_in = 8'hA5;
            for (int n = 1; n <= 12; n++) begin
                @(posedge clk);
                #1;
                bus2.signal_in = 8'h00;
                if (found == 0 && bus2.signal_out == 8'hA5) begin
                    found = n;
                    v_at = bus2.out_valid;
                end
            end
            bus2.enable = 1'b0;
            checks++;
            if (found != s + 1) begin
                errors++;
                $display("FAIL wide_latency sel=%0d: got %0d expected %0d", s, found, s + 1);
            end
            checks++;
            if (v_at !== 1'b1) begin
                errors++;
                $display("FAIL wide_valid sel=%0d: got %b expected 1", s, v_at);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/delay_line_var.md
Name: delay_line_var

Overview:
- Parametrised successor to the fixed 4-tap bit delay used in the tester's receive path.
- Aligns the reference PRBS stream to the looped-back stream before the error comparator.
- Generalises data width, minimum delay and selector width.
- Adds two features:
  - selector changes are applied only on an explicit load strobe;
  - a fill/settle counter drives out_valid, so the comparator ignores samples until the new alignment is filled.

Parameters:
- DATA_W, 1: width of signal_in / signal_out in bits.
- MIN_DELAY, 3: delay in enabled cycles when the active selector is 0; must be ≥ 1.
- SEL_W, 2: width of delay_select. Maximum delay MAX_DELAY = MIN_DELAY + 2^SEL_W − 1 (default 6).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  shift qualifier; stages and the settle counter advance only when enable=1.
- load  input  1  one-cycle strobe; captures delay_select into the active selector.
- delay_select  input  SEL_W  requested delay offset. Delay = MIN_DELAY + value.
- signal_in  input  DATA_W  sample entering the line.
- signal_out  output  DATA_W  delayed sample.
- out_valid  output  1  high when signal_out holds data shifted in under the current selector.
- active_sel  output  SEL_W  selector currently in effect.

Behaviour:
- Storage: MAX_DELAY-stage shift register, each stage DATA_W wide.
  - Enabled cycle: stage[0] ← signal_in and stage[k] ← stage[k−1].
  - enable=0: all stages hold.
- Output tap:
  - signal_out = stage[MIN_DELAY − 1 + active_sel], combinational from registers (no extra pipeline).
  - Latency: a sample applied with enable=1 appears on signal_out after exactly MIN_DELAY + active_sel enabled rising edges.
  - Disabled cycles stretch the wall-clock latency but do not change the enabled-edge count.
- Selector:
  - active_sel is a register, updated only when load=1 at a clock edge.
  - load is independent of enable.
  - delay_select changes without load have no effect.
  - The tap moves on the edge that captures load. signal_out switches combinationally in the following cycle; no glitch-free requirement beyond this.
- Settle counter cnt:
  - Width is enough to hold MAX_DELAY; saturates at MAX_DELAY.
  - Cleared to 0 by reset or by load.
  - Otherwise increments on each enabled edge.
  - load and enable in the same cycle: cnt becomes 0, not 1. The shift still occurs.
- out_valid = (cnt ≥ MIN_DELAY + active_sel), registered-state based.
  - Drops in the cycle after a load edge.
  - Reasserts after MIN_DELAY + new_sel further enabled edges.
  - Applies whether the new selector is smaller, larger or equal. Reloading the same value still restarts settling.
- Reset, which has priority over load and enable:
  - All stages = 0, active_sel = 0, cnt = 0.
  - Therefore signal_out = 0 and out_valid = 0 in the cycle after reset.
  - Reset mid-stream discards all history; no partial retention.
- Saturation: cnt stops at MAX_DELAY so arbitrarily long runs never wrap out_valid low.
- No X propagation: every register has a defined reset value.

Test Plan:
1. Reset, then enable=1 with signal_in = 1 for one cycle and 0 after, default params, active_sel=0 → signal_out=1 for exactly one cycle, 3 edges after injection. out_valid rises after edge 3.
2. Load delay_select=3 (delay 6), drive a 0x2D bit pattern MSB first, enable=1 → pattern reproduced on signal_out 6 edges later. out_valid low for 6 enabled edges after load, then high. active_sel=3.
3. Toggle delay_select 0↔2 without load while streaming → active_sel stays 0, latency stays 3, out_valid never drops.
4. With active_sel=1 and the line filled, hold enable=0 for 5 cycles mid-stream → signal_out and out_valid frozen. On re-enable, alignment resumes with no lost or duplicated sample.
5. Assert load and enable in the same cycle with delay_select=2 (delay 5) → cnt=0 after that edge, out_valid reasserts after exactly 5 further enabled edges. Sample from the load cycle exits at edge 5.
6. Assert reset for one cycle while streaming with out_valid=1 and active_sel=3 → next cycle: signal_out=0, out_valid=0, active_sel=0. Stream recovers with 3-edge latency. Also checked with DATA_W=8, MIN_DELAY=1, SEL_W=3: byte 0xA5 emerges after 1..8 edges for selectors 0..7.
